fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
Instruction-fetch stage of the SOIN-RV core. Holds the program counter and issues one request at a time over a req/gnt/rvalid instruction-memory port. It presents a fetched instruction, with its PC and PC+4, to decode through a valid/stall interface. It consumes the taken/not-taken result from branch/jump control plus the target address, redirects the PC, and squashes wrong-path instructions.

Parameters:
XLEN, 32, datapath and address width.
RESET_VECTOR, 32'h0000_0000, first PC fetched after reset release.

Ports:
i_clk  in  1  core clock, all state on rising edge.
i_rst  in  1  asynchronous reset, active-high.
i_B_J_result  in  1  branch taken or jump, from branch/jump control; a one-cycle pulse per resolved control transfer.
i_target  in  XLEN  redirect address, valid when i_B_J_result=1.
i_stall  in  1  decode cannot accept; hold output.
o_imem_req  out  1  fetch request.
o_imem_addr  out  XLEN  fetch address, word aligned.
i_imem_gnt  in  1  request accepted this cycle.
i_imem_rvalid  in  1  response data valid.
i_imem_rdata  in  32  response instruction.
o_instr  out  32  instruction to decode.
o_pc  out  XLEN  PC of o_instr.
o_pc4  out  XLEN  o_pc+4.
o_valid  out  1  o_instr is a real instruction.
o_flush  out  1  one-cycle pulse; decode/execute squash younger instructions.

Behaviour:
- Reset (async, i_rst=1): pc_q=RESET_VECTOR, state=IDLE, o_imem_req=0, o_imem_addr=RESET_VECTOR, o_instr=32'h0000_0013 (NOP), o_pc=RESET_VECTOR, o_pc4=RESET_VECTOR+4, o_valid=0, o_flush=0, discard_q=0.
- FSM states:
  - IDLE: go to REQ the first cycle after reset deasserts.
  - REQ: o_imem_req=1, o_imem_addr=pc_q. If gnt=1, latch fetch_pc=pc_q, set pc_q=pc_q+4, and go to WAIT.
  - WAIT: o_imem_req=0 and wait for rvalid.
    - On rvalid, if discard_q=0 and the output is free, load o_instr/o_pc/o_pc4 and set o_valid=1.
    - If the output is held (o_valid=1 and i_stall=1), park the response in a 1-entry skid register and stay in HOLD.
    - If no hold is needed, return to REQ.
  - HOLD: when i_stall drops, move the skid entry to the output and go to REQ.
- Only one outstanding request at any time. Memory latency is 1..N cycles; gnt may lag req by any number of cycles.
- Output handshake: the output advances only when i_stall=0. While i_stall=1, o_instr/o_pc/o_pc4/o_valid hold. When i_stall=0 and no new instruction arrives, o_valid=0 next cycle.
- PC arithmetic: +4 modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- Redirect (i_B_J_result=1):
  - Next cycle: pc_q=i_target, o_flush=1 for exactly one cycle, o_valid=0, skid cleared.
  - If in WAIT, set discard_q=1. The pending response is dropped on arrival, discard_q clears, and the FSM goes to REQ at the new pc_q.
  - If in REQ without gnt, the address switches to i_target next cycle.
  - If in REQ with gnt in the same cycle, treat the request as outstanding and discard it.
- Simultaneous events:
  - Redirect beats stall.
  - Redirect beats rvalid in the same cycle: the data is dropped.
  - Back-to-back redirects: the last target wins; discard_q stays set until the single outstanding response returns.
- Reset mid-transaction: everything returns to reset values. A late rvalid arriving in IDLE is ignored.

Optional Feature:
FETCH_MISALIGN_CHECK_EN:
- Defined: on a redirect with i_target[1:0]!=0, no PC change occurs and o_flush=1 as normal. Extra output o_misaligned pulses for one cycle, and o_bad_addr (XLEN) holds i_target until the next redirect. Fetch then stalls in IDLE until reset.
- Undefined: i_target[1:0] is forced to 0, with no extra ports.

Decomposition:
- Package soin_fetch_pkg holds:
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD}
  - constant NOP_INSTR=32'h0000_0013
  - constant PC_STEP=4
- One sub-module, fetch_skid_buf: 1-entry {instr, pc} holding register with load/drain/clear. The PC/FSM logic stays in the top.

Test Plan:
- Reset release, gnt and rvalid always 1 cycle late: addresses 0,4,8,12 in order; o_valid pulses each fetch; o_pc4=o_pc+4.
- i_stall=1 for 5 cycles while a response for PC 0x10 arrives: o_instr/o_pc hold the previous entry; 0x10 appears one cycle after the stall drops; nothing is lost or duplicated.
- Redirect to 0x200 while in WAIT for 0x8: o_flush=1 for one cycle; the 0x8 response is discarded; next o_imem_addr=0x200 and next valid o_pc=0x200.
- Redirect to 0x300 together with i_stall=1 and rvalid in the same cycle: redirect wins; o_valid=0; next fetch at 0x300.
- pc=32'hFFFF_FFFC fetched: next o_imem_addr=0.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102: o_misaligned=1 for one cycle; o_bad_addr=0x102; no further o_imem_req.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the SOIN-RV instruction-fetch stage.
package soin_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_pc_unit_skid_buf.sv
// One-entry {instr, pc} parking register for a response that arrives while decode holds the output.
module fetch_skid_buf
    import soin_fetch_pkg::*;
#(
    parameter int unsigned XLEN = 32
)(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_drain,
    input  logic            i_clear,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic            o_full
);

    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc;
    logic            r_full;

    // Clear wins over load so a redirect always empties the entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
            r_full  <= 1'b0;
        end else if (i_clear) begin
            r_full  <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_full  <= 1'b1;
        end else if (i_drain) begin
            r_full  <= 1'b0;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_full  = r_full;

endmodule

// File: rtl/fetch_pc_unit.sv
// SOIN-RV fetch stage: PC register, single-outstanding imem port, valid/stall output to decode.
// Optional build macro FETCH_MISALIGN_CHECK_EN traps misaligned redirect targets.
//   state | meaning
//   IDLE  | after reset (or trapped on a bad target); no request
//   REQ   | request pc_q, waiting for gnt
//   WAIT  | one request outstanding, waiting for rvalid
//   HOLD  | response parked in skid while decode stalls
module fetch_pc_unit
    import soin_fetch_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}}
)(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_B_J_result,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_stall,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc4,
    output logic            o_valid,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic            o_misaligned,
    output logic [XLEN-1:0] o_bad_addr,
`endif
    output logic            o_flush
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc_q;
    logic [XLEN-1:0] r_fetch_pc;
    logic            r_discard_q;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc4;
    logic            r_valid;
    logic            r_flush;

    logic [XLEN-1:0] w_target;
    logic            w_pc_load;
    logic            w_out_held;
    logic            w_rsp_keep;
    logic            w_outstanding;
    logic            w_skid_load;
    logic            w_skid_drain;
    logic            w_skid_full;
    logic [31:0]     w_skid_instr;
    logic [XLEN-1:0] w_skid_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic            w_misalign;
    logic            r_halt;
    logic            r_misaligned;
    logic [XLEN-1:0] r_bad_addr;

    assign w_misalign = i_B_J_result && (i_target[1:0] != 2'b00);
    assign w_pc_load  = i_B_J_result && !w_misalign;
    assign w_target   = i_target;
`else
    assign w_pc_load  = i_B_J_result;
    assign w_target   = i_target & {{(XLEN-2){1'b1}}, 2'b00};
`endif

    assign w_out_held    = r_valid && i_stall;
    assign w_rsp_keep    = (r_state == WAIT) && i_imem_rvalid && !r_discard_q && !i_B_J_result;
    // A request granted in the same cycle as a redirect is still in flight and must be dropped.
    assign w_outstanding = ((r_state == REQ) && i_imem_gnt) ||
                           ((r_state == WAIT) && !i_imem_rvalid);
    assign w_skid_load   = w_rsp_keep && w_out_held;
    assign w_skid_drain  = !i_B_J_result && !w_out_held && w_skid_full;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ:  if (i_imem_gnt) w_state_nxt = WAIT;
            WAIT: if (i_imem_rvalid) w_state_nxt = w_skid_load ? HOLD : REQ;
            HOLD: if (!i_stall || i_B_J_result) w_state_nxt = REQ;
            default: w_state_nxt = IDLE;
        endcase
`ifdef FETCH_MISALIGN_CHECK_EN
        if (r_halt || w_misalign) w_state_nxt = IDLE;
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_pc_q      <= RESET_VECTOR;
            r_fetch_pc  <= RESET_VECTOR;
            r_discard_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pc_load) begin
                r_pc_q <= w_target;
            end else if ((r_state == REQ) && i_imem_gnt) begin
                r_pc_q <= r_pc_q + STEP;
            end
            if ((r_state == REQ) && i_imem_gnt) begin
                r_fetch_pc <= r_pc_q;
            end
            if (i_B_J_result && w_outstanding) begin
                r_discard_q <= 1'b1;
            end else if ((r_state == WAIT) && i_imem_rvalid) begin
                r_discard_q <= 1'b0;
            end
        end
    end

    // Decode-facing register: a redirect kills it, a stall freezes it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_instr <= NOP_INSTR;
            r_pc    <= RESET_VECTOR;
            r_pc4   <= RESET_VECTOR + STEP;
            r_valid <= 1'b0;
            r_flush <= 1'b0;
        end else begin
            r_flush <= i_B_J_result;
            if (i_B_J_result) begin
                r_valid <= 1'b0;
            end else if (!w_out_held) begin
                if (w_rsp_keep) begin
                    r_instr <= i_imem_rdata;
                    r_pc    <= r_fetch_pc;
                    r_pc4   <= r_fetch_pc + STEP;
                    r_valid <= 1'b1;
                end else if (w_skid_full) begin
                    r_instr <= w_skid_instr;
                    r_pc    <= w_skid_pc;
                    r_pc4   <= w_skid_pc + STEP;
                    r_valid <= 1'b1;
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_halt       <= 1'b0;
            r_misaligned <= 1'b0;
            r_bad_addr   <= '0;
        end else begin
            r_misaligned <= w_misalign;
            if (w_misalign) begin
                r_halt     <= 1'b1;
                r_bad_addr <= i_target;
            end else if (i_B_J_result) begin
                r_bad_addr <= '0;
            end
        end
    end

    assign o_misaligned = r_misaligned;
    assign o_bad_addr   = r_bad_addr;
`endif

    fetch_skid_buf #(
        .XLEN (XLEN)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_clear (i_B_J_result),
        .i_instr (i_imem_rdata),
        .i_pc    (r_fetch_pc),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc),
        .o_full  (w_skid_full)
    );

    assign o_imem_req  = (r_state == REQ);
    assign o_imem_addr = r_pc_q;
    assign o_instr     = r_instr;
    assign o_pc        = r_pc;
    assign o_pc4       = r_pc4;
    assign o_valid     = r_valid;
    assign o_flush     = r_flush;

endmodule
